// File: rtl/rob_commit.sv
// Reorder buffer: in-order commit of out-of-order completions.
// Redirecting entries flush all younger work when they retire.
module rob_commit #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    input  logic [4:0]          alloc_rd_addr,
    input  logic                alloc_rf_w_en,
    input  logic [ADDR_LEN-1:0] alloc_pc,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                cmpl_valid,
    input  logic [TAG_W-1:0]    cmpl_tag,
    input  logic [WIDTH-1:0]    cmpl_data,
    input  logic                cmpl_redirect,
    input  logic [ADDR_LEN-1:0] cmpl_target,
    input  logic [4:0]          src1_addr,
    input  logic [4:0]          src2_addr,
    output logic                src1_hit,
    output logic                src1_ready,
    output logic [WIDTH-1:0]    src1_data,
    output logic [TAG_W-1:0]    src1_tag,
    output logic                src2_hit,
    output logic                src2_ready,
    output logic [WIDTH-1:0]    src2_data,
    output logic [TAG_W-1:0]    src2_tag,
    output logic                commit_valid,
    output logic [4:0]          commit_rd_addr,
    output logic                commit_rf_w_en,
    output logic [WIDTH-1:0]    commit_data,
    output logic [ADDR_LEN-1:0] commit_pc,
    output logic                flush_o,
    output logic [ADDR_LEN-1:0] flush_target,
    output logic [TAG_W:0]      count,
    output logic                empty,
    output logic                full
);

    localparam logic [TAG_W:0] FULL_C = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]    valid_q;
    logic [DEPTH-1:0]    done_q;
    logic [DEPTH-1:0]    redir_q;
    logic [DEPTH-1:0]    wen_q;
    logic [4:0]          rd_q   [DEPTH];
    logic [ADDR_LEN-1:0] pc_q   [DEPTH];
    logic [ADDR_LEN-1:0] tgt_q  [DEPTH];
    logic [WIDTH-1:0]    data_q [DEPTH];

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic alloc_fire;
    logic cmpl_fire;
    logic [TAG_W-1:0] idx;

    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_C);
    assign alloc_tag   = tail_q;

    assign commit_valid = valid_q[head_q] && done_q[head_q];
    assign flush_o      = commit_valid && redir_q[head_q];
    assign alloc_ready  = !full && !flush_o;
    assign alloc_fire   = alloc_valid && alloc_ready;
    // A flush drops any completion arriving in the same cycle.
    assign cmpl_fire    = cmpl_valid && valid_q[cmpl_tag]
                       && !done_q[cmpl_tag] && !flush_o;

    assign commit_rd_addr = commit_valid ? rd_q[head_q] : '0;
    assign commit_rf_w_en = commit_valid && wen_q[head_q]
                         && (rd_q[head_q] != 5'd0);
    assign commit_data    = commit_valid ? data_q[head_q] : '0;
    assign commit_pc      = commit_valid ? pc_q[head_q] : '0;
    assign flush_target   = flush_o ? tgt_q[head_q] : '0;

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_o) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_valid)
                head_d = head_q + TAG_W'(1);
            if (alloc_fire)
                tail_d = tail_q + TAG_W'(1);
            if (alloc_fire && !commit_valid)
                count_d = count_q + (TAG_W+1)'(1);
            else if (!alloc_fire && commit_valid)
                count_d = count_q - (TAG_W+1)'(1);
        end
    end

    // Operand lookup: scan oldest to youngest so the last match wins.
    always_comb begin
        idx        = '0;
        src1_hit   = 1'b0;
        src1_tag   = '0;
        src2_hit   = 1'b0;
        src2_tag   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + TAG_W'(i);
            if (valid_q[idx] && wen_q[idx] && (src1_addr != 5'd0)
                && (rd_q[idx] == src1_addr)) begin
                src1_hit = 1'b1;
                src1_tag = idx;
            end
            if (valid_q[idx] && wen_q[idx] && (src2_addr != 5'd0)
                && (rd_q[idx] == src2_addr)) begin
                src2_hit = 1'b1;
                src2_tag = idx;
            end
        end
        src1_ready = src1_hit && done_q[src1_tag];
        src2_ready = src2_hit && done_q[src2_tag];
        src1_data  = src1_ready ? data_q[src1_tag] : '0;
        src2_data  = src2_ready ? data_q[src2_tag] : '0;
    end

    // Entry state: allocate at tail, complete by tag, retire at head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            redir_q <= '0;
            wen_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                pc_q[i]   <= '0;
                tgt_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (flush_o) begin
                valid_q <= '0;
            end else begin
                if (alloc_fire) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                    redir_q[tail_q] <= 1'b0;
                    wen_q[tail_q]   <= alloc_rf_w_en;
                    rd_q[tail_q]    <= alloc_rd_addr;
                    pc_q[tail_q]    <= alloc_pc;
                end
                if (cmpl_fire) begin
                    done_q[cmpl_tag]  <= 1'b1;
                    redir_q[cmpl_tag] <= cmpl_redirect;
                    data_q[cmpl_tag]  <= cmpl_data;
                    tgt_q[cmpl_tag]   <= cmpl_target;
                end
                if (commit_valid)
                    valid_q[head_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit (DEPTH=8).
// Table-driven in-order commit plus hand-written corner sequences.
module tb_rob_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rd_addr;
    logic        alloc_rf_w_en;
    logic [31:0] alloc_pc;
    logic [2:0]  alloc_tag;
    logic        cmpl_valid;
    logic [2:0]  cmpl_tag;
    logic [31:0] cmpl_data;
    logic        cmpl_redirect;
    logic [31:0] cmpl_target;
    logic [4:0]  src1_addr, src2_addr;
    logic        src1_hit, src1_ready, src2_hit, src2_ready;
    logic [31:0] src1_data, src2_data;
    logic [2:0]  src1_tag, src2_tag;
    logic        commit_valid;
    logic [4:0]  commit_rd_addr;
    logic        commit_rf_w_en;
    logic [31:0] commit_data;
    logic [31:0] commit_pc;
    logic        flush_o;
    logic [31:0] flush_target;
    logic [3:0]  count;
    logic        empty, full;

    int checks = 0;
    int failures = 0;

    rob_commit dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd_addr(alloc_rd_addr), .alloc_rf_w_en(alloc_rf_w_en),
        .alloc_pc(alloc_pc), .alloc_tag(alloc_tag),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
        .cmpl_data(cmpl_data), .cmpl_redirect(cmpl_redirect),
        .cmpl_target(cmpl_target),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .src1_hit(src1_hit), .src1_ready(src1_ready),
        .src1_data(src1_data), .src1_tag(src1_tag),
        .src2_hit(src2_hit), .src2_ready(src2_ready),
        .src2_data(src2_data), .src2_tag(src2_tag),
        .commit_valid(commit_valid), .commit_rd_addr(commit_rd_addr),
        .commit_rf_w_en(commit_rf_w_en), .commit_data(commit_data),
        .commit_pc(commit_pc), .flush_o(flush_o),
        .flush_target(flush_target), .count(count),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] apc;
        logic        cv;
        logic [2:0]  ctag;
        logic [31:0] cdat;
        logic [4:0]  s1;
        logic        e_ardy;
        logic [2:0]  e_atag;
        logic        e_cv;
        logic [4:0]  e_crd;
        logic        e_cwe;
        logic [31:0] e_cdat;
        logic [31:0] e_cpc;
        logic [3:0]  e_cnt;
        logic        e_hit;
        logic        e_rdy;
        logic [2:0]  e_stag;
        logic [31:0] e_sdat;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        alloc_rd_addr = 5'd0;
        alloc_rf_w_en = 1'b1;
        alloc_pc      = 32'd0;
        cmpl_valid    = 1'b0;
        cmpl_tag      = 3'd0;
        cmpl_data     = 32'd0;
        cmpl_redirect = 1'b0;
        cmpl_target   = 32'd0;
        src1_addr     = 5'd0;
        src2_addr     = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] pc);
        alloc_valid   = 1'b1;
        alloc_rd_addr = rd;
        alloc_pc      = pc;
        tick();
        alloc_valid   = 1'b0;
    endtask

    task automatic cmpl(input logic [2:0] t, input logic [31:0] d,
                        input logic red, input logic [31:0] tgt);
        cmpl_valid    = 1'b1;
        cmpl_tag      = t;
        cmpl_data     = d;
        cmpl_redirect = red;
        cmpl_target   = tgt;
    endtask

    initial begin
        tv[0] = '{1,1,0, 0,0,0, 1, 1,0,0,0,0,0,0,0, 0,0,0,0};
        tv[1] = '{1,2,4, 0,0,0, 1, 1,1,0,0,0,0,0,1, 1,0,0,0};
        tv[2] = '{1,3,8, 0,0,0, 1, 1,2,0,0,0,0,0,2, 1,0,0,0};
        tv[3] = '{0,0,0, 1,2,32'hA, 3, 1,3,0,0,0,0,0,3, 1,0,2,0};
        tv[4] = '{0,0,0, 1,0,32'hB, 3, 1,3,0,0,0,0,0,3, 1,1,2,32'hA};
        tv[5] = '{0,0,0, 1,1,32'hC, 1,
                  1,3,1,1,1,32'hB,0,3, 1,1,0,32'hB};
        tv[6] = '{0,0,0, 0,0,0, 2,
                  1,3,1,2,1,32'hC,4,2, 1,1,1,32'hC};
        tv[7] = '{0,0,0, 0,0,0, 3,
                  1,3,1,3,1,32'hA,8,1, 1,1,2,32'hA};
        tv[8] = '{0,0,0, 0,0,0, 3, 1,3,0,0,0,0,0,0, 0,0,0,0};

        // reset values
        idle();
        reset = 1'b0;
        #2;
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_count", count, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        reset = 1'b1;
        tick();

        // table: out-of-order completion, in-order commit
        for (int i = 0; i < 9; i++) begin
            alloc_valid   = tv[i].av;
            alloc_rd_addr = tv[i].ard;
            alloc_pc      = tv[i].apc;
            cmpl_valid    = tv[i].cv;
            cmpl_tag      = tv[i].ctag;
            cmpl_data     = tv[i].cdat;
            cmpl_redirect = 1'b0;
            src1_addr     = tv[i].s1;
            src2_addr     = 5'd0;
            #1;
            chk($sformatf("v%0d_alloc_ready", i), alloc_ready, tv[i].e_ardy);
            chk($sformatf("v%0d_alloc_tag", i), alloc_tag, tv[i].e_atag);
            chk($sformatf("v%0d_commit_valid", i), commit_valid, tv[i].e_cv);
            chk($sformatf("v%0d_commit_rd", i), commit_rd_addr, tv[i].e_crd);
            chk($sformatf("v%0d_commit_we", i), commit_rf_w_en, tv[i].e_cwe);
            chk($sformatf("v%0d_commit_data", i), commit_data, tv[i].e_cdat);
            chk($sformatf("v%0d_commit_pc", i), commit_pc, tv[i].e_cpc);
            chk($sformatf("v%0d_count", i), count, tv[i].e_cnt);
            chk($sformatf("v%0d_flush", i), flush_o, 0);
            chk($sformatf("v%0d_s1_hit", i), src1_hit, tv[i].e_hit);
            chk($sformatf("v%0d_s1_ready", i), src1_ready, tv[i].e_rdy);
            chk($sformatf("v%0d_s1_tag", i), src1_tag, tv[i].e_stag);
            chk($sformatf("v%0d_s1_data", i), src1_data, tv[i].e_sdat);
            chk($sformatf("v%0d_s2_hit", i), src2_hit, 0);
            tick();
        end

        // full, no same-cycle slot reuse, wrap to tag 0
        do_reset();
        alloc_valid   = 1'b1;
        alloc_rd_addr = 5'd4;
        for (int i = 0; i < 8; i++) begin
            alloc_pc = 32'(i * 4);
            #1;
            chk($sformatf("full_tag%0d", i), alloc_tag, 32'(i));
            tick();
        end
        #1;
        chk("full_full", full, 1);
        chk("full_ready", alloc_ready, 0);
        chk("full_count", count, 8);
        cmpl(3'd0, 32'h1, 1'b0, 32'd0);
        tick();
        cmpl_valid = 1'b0;
        #1;
        chk("full_commit_valid", commit_valid, 1);
        chk("full_ready_on_commit", alloc_ready, 0);
        tick();
        #1;
        chk("full_count_after", count, 7);
        chk("full_ready_after", alloc_ready, 1);
        chk("full_wrap_tag", alloc_tag, 0);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("full_refill_count", count, 8);
        chk("full_refill_tail", alloc_tag, 1);

        // redirect flush
        do_reset();
        for (int i = 0; i < 4; i++)
            alloc(5'(6 + i), 32'(32'h20 + i * 4));
        cmpl(3'd1, 32'h99, 1'b1, 32'h100);
        tick();
        cmpl(3'd0, 32'h5, 1'b0, 32'd0);
        tick();
        cmpl_valid = 1'b0;
        #1;
        chk("rd_c0_valid", commit_valid, 1);
        chk("rd_c0_pc", commit_pc, 32'h20);
        chk("rd_c0_flush", flush_o, 0);
        tick();
        alloc_valid = 1'b1;
        alloc_rd_addr = 5'd9;
        cmpl(3'd2, 32'h7, 1'b0, 32'd0);
        #1;
        chk("rd_c1_valid", commit_valid, 1);
        chk("rd_c1_pc", commit_pc, 32'h24);
        chk("rd_c1_rd", commit_rd_addr, 7);
        chk("rd_c1_we", commit_rf_w_en, 1);
        chk("rd_c1_data", commit_data, 32'h99);
        chk("rd_flush", flush_o, 1);
        chk("rd_flush_target", flush_target, 32'h100);
        chk("rd_alloc_ready", alloc_ready, 0);
        tick();
        idle();
        #1;
        chk("rd_post_count", count, 0);
        chk("rd_post_empty", empty, 1);
        chk("rd_post_alloc_tag", alloc_tag, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_no_commit%0d", i), commit_valid, 0);
            tick();
        end

        // operand lookup
        do_reset();
        alloc(5'd5, 32'h0);
        alloc(5'd5, 32'h4);
        src1_addr = 5'd5;
        src2_addr = 5'd0;
        #1;
        chk("lk_hit", src1_hit, 1);
        chk("lk_tag", src1_tag, 1);
        chk("lk_ready", src1_ready, 0);
        chk("lk_data", src1_data, 0);
        chk("lk_s2_hit", src2_hit, 0);
        chk("lk_s2_tag", src2_tag, 0);
        cmpl(3'd1, 32'h55, 1'b0, 32'd0);
        #1;
        chk("lk_same_cycle_ready", src1_ready, 0);
        tick();
        cmpl_valid = 1'b0;
        src2_addr = 5'd5;
        #1;
        chk("lk_ready_after", src1_ready, 1);
        chk("lk_data_after", src1_data, 32'h55);
        chk("lk_s2_data", src2_data, 32'h55);
        chk("lk_s2_tag5", src2_tag, 1);

        // rd=0 write suppression, freed and done-tag completions
        do_reset();
        alloc(5'd0, 32'h40);
        cmpl(3'd0, 32'h77, 1'b0, 32'd0);
        tick();
        cmpl_valid = 1'b0;
        #1;
        chk("x0_commit_valid", commit_valid, 1);
        chk("x0_commit_we", commit_rf_w_en, 0);
        chk("x0_commit_data", commit_data, 32'h77);
        tick();
        cmpl(3'd0, 32'h99, 1'b0, 32'd0);
        #1;
        chk("freed_count", count, 0);
        tick();
        cmpl_valid = 1'b0;
        #1;
        chk("freed_no_commit", commit_valid, 0);
        chk("freed_empty", empty, 1);
        alloc(5'd7, 32'h44);
        alloc(5'd8, 32'h48);
        cmpl(3'd2, 32'h11, 1'b0, 32'd0);
        tick();
        cmpl(3'd2, 32'h22, 1'b0, 32'd0);
        tick();
        cmpl_valid = 1'b0;
        src1_addr = 5'd8;
        #1;
        chk("dup_ready", src1_ready, 1);
        chk("dup_data", src1_data, 32'h11);
        chk("dup_head_wait", commit_valid, 0);
        cmpl(3'd1, 32'h33, 1'b0, 32'd0);
        tick();
        cmpl_valid = 1'b0;
        #1;
        chk("dup_c1_data", commit_data, 32'h33);
        chk("dup_c1_rd", commit_rd_addr, 7);
        tick();
        #1;
        chk("dup_c2_valid", commit_valid, 1);
        chk("dup_c2_data", commit_data, 32'h11);
        chk("dup_c2_rd", commit_rd_addr, 8);
        tick();
        #1;
        chk("dup_empty", empty, 1);

        // asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 5; i++)
            alloc(5'(i + 1), 32'(i * 4));
        #1;
        chk("ar_count_before", count, 5);
        reset = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_alloc_tag", alloc_tag, 0);
        reset = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd_addr = 5'd3;
        #1;
        chk("ar_next_tag", alloc_tag, 0);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("ar_count_after", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
